// File: rtl/dispatch_ctrl.sv
// Dispatch controller: checks reservation-station credits and ROB space, then issues one tagged dispatch per cycle.
// Optional stall-cycle counter is built only when DISPATCH_PERF_EN is defined.
module dispatch_ctrl #(
  parameter int RS_DEPTH    = 4,
  parameter int ROB_DEPTH   = 16,
  parameter int TAG_W       = 4,
  parameter int RECOVER_CYC = 2
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             inst_valid_i,
  output logic             inst_ready_o,
  input  logic [31:0]      pc_i,
  input  logic             alu_i,
  input  logic             lsu_i,
  input  logic             mul_i,
  input  logic             br_i,
  input  logic [4:0]       prd_addr_i,
  input  logic [3:0]       rs_free_i,
  input  logic             rob_retire_i,
  input  logic             flush_i,
  output logic             dispatch_valid_o,
  output logic [3:0]       fu_sel_o,
  output logic [31:0]      pc_o,
  output logic [4:0]       prd_addr_o,
  output logic [TAG_W-1:0] rob_tag_o,
  output logic             illegal_o,
  output logic [31:0]      perf_stall_cnt_o
);

  localparam int CW = $clog2(RS_DEPTH + 1);
  localparam int RW = $clog2(ROB_DEPTH + 1);
  localparam int KW = (RECOVER_CYC > 1) ? $clog2(RECOVER_CYC) : 1;
  localparam logic [CW-1:0]    CRED_MAX  = CW'(RS_DEPTH);
  localparam logic [RW-1:0]    ROB_MAX   = RW'(ROB_DEPTH);
  localparam logic [TAG_W-1:0] TAIL_LAST = TAG_W'(ROB_DEPTH - 1);
  localparam logic [KW-1:0]    REC_LOAD  = KW'(RECOVER_CYC - 1);

  typedef enum logic {RUN, RECOVER} state_t;

  state_t           state;
  logic [KW-1:0]    rec_cnt;
  logic [CW-1:0]    credits [4];
  logic [RW-1:0]    rob_count;
  logic [TAG_W-1:0] tail;

  logic [3:0] sel;
  logic       legal;
  logic [3:0] has_credit;
  logic       credit_ok;
  logic       accept;
  logic [3:0] take;
  logic       retire_eff;

  assign sel   = {br_i, mul_i, lsu_i, alu_i};
  assign legal = (sel != 4'd0) && ((sel & (sel - 4'd1)) == 4'd0);

  always_comb begin
    has_credit = '0;
    for (int i = 0; i < 4; i++) begin
      has_credit[i] = (credits[i] != '0);
    end
  end

  // Illegal instructions need no station, so they only wait on ROB space.
  assign credit_ok    = !legal || ((sel & has_credit) != 4'd0);
  assign inst_ready_o = (state == RUN) && !flush_i && (rob_count < ROB_MAX) && credit_ok;
  assign accept       = inst_valid_i && inst_ready_o;
  assign take         = (accept && legal) ? sel : 4'd0;
  assign retire_eff   = rob_retire_i && (rob_count != '0);

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state            <= RUN;
      rec_cnt          <= '0;
      rob_count        <= '0;
      tail             <= '0;
      for (int i = 0; i < 4; i++) begin
        credits[i] <= CRED_MAX;
      end
      dispatch_valid_o <= 1'b0;
      illegal_o        <= 1'b0;
      fu_sel_o         <= '0;
      pc_o             <= '0;
      prd_addr_o       <= '0;
      rob_tag_o        <= '0;
    end else begin
      dispatch_valid_o <= accept;
      illegal_o        <= accept && !legal;
      if (accept) begin
        fu_sel_o   <= legal ? sel : 4'd0;
        pc_o       <= pc_i;
        prd_addr_o <= prd_addr_i;
        rob_tag_o  <= tail;
      end

      // Flush wipes all speculative bookkeeping and restarts the recovery window.
      if (flush_i) begin
        state     <= RECOVER;
        rec_cnt   <= REC_LOAD;
        rob_count <= '0;
        tail      <= '0;
        for (int i = 0; i < 4; i++) begin
          credits[i] <= CRED_MAX;
        end
      end else if (state == RECOVER) begin
        if (rec_cnt == '0) begin
          state <= RUN;
        end else begin
          rec_cnt <= rec_cnt - KW'(1);
        end
      end else begin
        for (int i = 0; i < 4; i++) begin
          if (take[i] && !rs_free_i[i]) begin
            credits[i] <= credits[i] - CW'(1);
          end else if (!take[i] && rs_free_i[i] && (credits[i] != CRED_MAX)) begin
            credits[i] <= credits[i] + CW'(1);
          end
        end
        rob_count <= rob_count + RW'(accept) - RW'(retire_eff);
        if (accept) begin
          tail <= (tail == TAIL_LAST) ? '0 : tail + TAG_W'(1);
        end
      end
    end
  end

`ifdef DISPATCH_PERF_EN
  logic [31:0] stall_cnt;

  // Counts cycles where decode had work but was held off; flush leaves it alone.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      stall_cnt <= '0;
    end else if (inst_valid_i && !inst_ready_o && (stall_cnt != 32'hFFFF_FFFF)) begin
      stall_cnt <= stall_cnt + 32'd1;
    end
  end

  assign perf_stall_cnt_o = stall_cnt;
`else
  assign perf_stall_cnt_o = 32'd0;
`endif

endmodule
